// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stall/flush sequencer: state encoding,
// register-index width, the per-cycle hazard action code and the helper
// functions that resolve hazard priority.
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DSTALL = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;

    localparam int REG_W = 3;

    // One action per cycle. The outputs and the next state are both derived
    // from this code, so the two cannot disagree about which hazard won.
    typedef enum logic [2:0] {
        ACT_NONE     = 3'd0,
        ACT_FREEZE   = 3'd1,
        ACT_FLUSH    = 3'd2,
        ACT_IBUBBLE  = 3'd3,
        ACT_LOAD_USE = 3'd4,
        ACT_HALT     = 3'd5,
        ACT_DRAIN    = 3'd6
    } act_e;

    function automatic logic load_use_hit(
        input logic             memread,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs,
        input logic             rs_valid,
        input logic [REG_W-1:0] rt,
        input logic             rt_valid
    );
        return memread & ((rs_valid & (rs == rd)) | (rt_valid & (rt == rd)));
    endfunction

    // Hazard priority while the pipe is running. A pending flush is treated
    // exactly like a fresh branch so it lands in the first unfrozen cycle.
    function automatic act_e run_priority(
        input logic dmem,
        input logic branch,
        input logic pend,
        input logic imem,
        input logic load_use,
        input logic halt
    );
        if (dmem)               return ACT_FREEZE;
        else if (branch | pend) return ACT_FLUSH;
        else if (imem)          return ACT_IBUBBLE;
        else if (load_use)      return ACT_LOAD_USE;
        else if (halt)          return ACT_HALT;
        else                    return ACT_NONE;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-low reset, clears the count
//   inc    - count one this cycle
//   count  - current value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Turns hazard inputs
// into PC / IF/ID / ID/EX write enables, flushes and the IF/ID stall tag.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | normal issue, hazards resolved by priority
//   ST_DSTALL | data memory busy, whole pipe frozen; branches remembered
//   ST_HALT   | HALT retired from ID; PC/IF/ID frozen, EX drains bubbles
//
// Ports:
//   clk, rst                      - clock, async active-low reset
//   dmem_stall, imem_stall        - memory not-ready indications
//   branch_taken                  - EX resolved a taken branch/jump
//   idex_memread, idex_rd         - load in ID/EX and its destination
//   ifid_rs/rt(_valid)            - sources read by the instruction in IF/ID
//   halt_id                       - HALT decoded in ID
//   pc_write, ifid_write, idex_write - register load enables
//   ifid_flush, idex_flush        - load NOP / bubble
//   ifid_stall                    - bubble tag into IF/ID
//   halted                        - pipeline permanently stopped
//   stall_cnt                     - saturating count of frozen-PC cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dmem_stall,
    input  logic             imem_stall,
    input  logic             branch_taken,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_rs_valid,
    input  logic             ifid_rt_valid,
    input  logic             halt_id,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             ifid_stall,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [1:0] state;
    logic [1:0] next_state;
    logic       flush_pend;
    logic       next_flush_pend;
    logic       load_use;
    logic       stall_inc;
    act_e       act;

    assign load_use = load_use_hit(idex_memread, idex_rd, ifid_rs, ifid_rs_valid,
                                   ifid_rt, ifid_rt_valid);

    // DSTALL resolves like RUN: while dmem_stall holds, the freeze wins;
    // the cycle it drops, normal priority (including a pending flush) applies.
    // Outputs are forced to the idle defaults while reset is asserted.
    always_comb begin
        act = ACT_NONE;
        if (rst) begin
            case (state)
                ST_RUN,
                ST_DSTALL: act = run_priority(dmem_stall, branch_taken, flush_pend,
                                              imem_stall, load_use, halt_id);
                ST_HALT:   act = ACT_DRAIN;
                default:   act = ACT_NONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            flush_pend <= 1'b0;
        end else begin
            state      <= next_state;
            flush_pend <= next_flush_pend;
        end
    end

    always_comb begin
        next_state      = ST_RUN;
        next_flush_pend = flush_pend;
        case (act)
            ACT_FREEZE: begin
                next_state = ST_DSTALL;
                if (branch_taken) begin
                    next_flush_pend = 1'b1;
                end
            end
            ACT_FLUSH: begin
                next_flush_pend = 1'b0;
            end
            ACT_HALT,
            ACT_DRAIN: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase
    end

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        idex_write = 1'b1;
        ifid_flush = 1'b0;
        ifid_stall = 1'b0;
        idex_flush = 1'b0;
        case (act)
            ACT_FREEZE: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_write = 1'b0;
            end
            ACT_FLUSH: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            ACT_IBUBBLE: begin
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
                ifid_stall = 1'b1;
            end
            ACT_LOAD_USE: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
            ACT_HALT: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end
            ACT_DRAIN: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
            default: begin
                pc_write   = 1'b1;
            end
        endcase
    end

    assign halted    = (state == ST_HALT);
    assign stall_inc = ~pc_write & (state != ST_HALT);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dmem_stall = 1'b0, imem_stall = 1'b0, branch_taken = 1'b0;
    logic idex_memread = 1'b0;
    logic [2:0] idex_rd = '0, ifid_rs = '0, ifid_rt = '0;
    logic ifid_rs_valid = 1'b0, ifid_rt_valid = 1'b0, halt_id = 1'b0;
    logic pc_write, ifid_write, ifid_flush, ifid_stall, idex_write, idex_flush, halted;
    logic [CNT_W-1:0] stall_cnt;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .dmem_stall(dmem_stall), .imem_stall(imem_stall), .branch_taken(branch_taken),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_rs_valid(ifid_rs_valid), .ifid_rt_valid(ifid_rt_valid),
        .halt_id(halt_id),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .ifid_stall(ifid_stall), .idex_write(idex_write), .idex_flush(idex_flush),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pc_write, ifid_write, ifid_flush, ifid_stall, idex_write, idex_flush, halted;
        int   cnt;
        int   cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: architectural facts only (stopped?, branch owed?, count).
    bit m_halted = 0, m_pend = 0;
    int m_cnt = 0;
    bit n_halted = 0, n_pend = 0;
    int n_cnt = 0;

    function automatic void chk(input string name, input int act_v, input int exp_v, input int c);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act_v, exp_v);
        end
    endfunction

    task automatic step(input bit r, input bit dm, input bit im, input bit br,
                        input bit mr, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [2:0] rt, input bit rsv, input bit rtv, input bit h);
        exp_t e;
        bit   lu;
        @(posedge clk);
        m_halted = n_halted; m_pend = n_pend; m_cnt = n_cnt;
        #1;
        cyc++;
        rst = r; dmem_stall = dm; imem_stall = im; branch_taken = br;
        idex_memread = mr; idex_rd = rd; ifid_rs = rs; ifid_rt = rt;
        ifid_rs_valid = rsv; ifid_rt_valid = rtv; halt_id = h;
        if (!r) begin
            m_halted = 0; m_pend = 0; m_cnt = 0;
        end
        e.pc_write = 1; e.ifid_write = 1; e.idex_write = 1;
        e.ifid_flush = 0; e.ifid_stall = 0; e.idex_flush = 0;
        e.halted = m_halted; e.cnt = m_cnt; e.cyc = cyc;
        n_halted = m_halted; n_pend = m_pend; n_cnt = m_cnt;
        lu = mr && ((rsv && rs == rd) || (rtv && rt == rd));
        if (!r) begin
            n_halted = 0; n_pend = 0; n_cnt = 0;
        end else if (m_halted) begin
            e.pc_write = 0; e.ifid_write = 0; e.idex_flush = 1;
        end else if (dm) begin
            e.pc_write = 0; e.ifid_write = 0; e.idex_write = 0;
            if (br) n_pend = 1;
        end else if (br || m_pend) begin
            e.ifid_flush = 1; e.idex_flush = 1; n_pend = 0;
        end else if (im) begin
            e.pc_write = 0; e.ifid_flush = 1; e.ifid_stall = 1;
        end else if (lu) begin
            e.pc_write = 0; e.ifid_write = 0; e.idex_flush = 1;
        end else if (h) begin
            e.pc_write = 0; e.ifid_write = 0; n_halted = 1;
        end
        if (r && !m_halted && !e.pc_write)
            n_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents a fresh set of control outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pc_write",   int'(pc_write),   int'(e.pc_write),   e.cyc);
                chk("ifid_write", int'(ifid_write), int'(e.ifid_write), e.cyc);
                chk("ifid_flush", int'(ifid_flush), int'(e.ifid_flush), e.cyc);
                chk("ifid_stall", int'(ifid_stall), int'(e.ifid_stall), e.cyc);
                chk("idex_write", int'(idex_write), int'(e.idex_write), e.cyc);
                chk("idex_flush", int'(idex_flush), int'(e.idex_flush), e.cyc);
                chk("halted",     int'(halted),     int'(e.halted),     e.cyc);
                chk("stall_cnt",  int'(stall_cnt),  e.cnt,              e.cyc);
            end
        end
    end

    initial begin
        int halt_age;
        bit dm, im, br, mr, rsv, rtv, h, r;
        logic [2:0] rd, rs, rt;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 3, 3, 3, 1, 1, 1);
        idle(2);

        // load-use on rs
        step(1, 0, 0, 0, 1, 3, 3, 0, 1, 0, 0);
        idle(2);
        // branch together with load-use
        step(1, 0, 0, 1, 1, 5, 1, 5, 0, 1, 0);
        idle(2);
        // dmem freeze for 4 cycles, branch in the second
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // instruction memory miss for 2 cycles
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // valid flag gating: matching register but source not read
        step(1, 0, 0, 0, 1, 2, 2, 2, 0, 0, 0);
        // repeated load-use drives the counter into saturation
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 1, 4, 0, 4, 0, 1, 0);
        idle(2);
        // halt, stay halted, then reset mid-halt
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(4);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // reset in the middle of a freeze with a branch owed
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        halt_age = 0;
        for (int i = 0; i < 4000; i++) begin
            dm  = ($urandom_range(0, 6) == 0);
            im  = ($urandom_range(0, 5) == 0);
            br  = ($urandom_range(0, 5) == 0);
            mr  = ($urandom_range(0, 2) == 0);
            rd  = 3'($urandom_range(0, 7));
            rs  = ($urandom_range(0, 2) == 0) ? rd : 3'($urandom_range(0, 7));
            rt  = ($urandom_range(0, 2) == 0) ? rd : 3'($urandom_range(0, 7));
            rsv = $urandom_range(0, 1) != 0;
            rtv = $urandom_range(0, 1) != 0;
            h   = ($urandom_range(0, 30) == 0);
            halt_age = n_halted ? halt_age + 1 : 0;
            r   = !((halt_age > 4 && $urandom_range(0, 2) == 0) || $urandom_range(0, 250) == 0);
            step(r, dm, im, br, mr, rd, rs, rt, rsv, rtv, h);
        end
        idle(1);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
